// File: rtl/data_mem_if.sv
// MEM-stage data memory bus: pipeline request signals plus responder status.
interface data_mem_if;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [3:0]  mem_read;
  logic [2:0]  mem_write;
  logic [31:0] read_data;
  logic        busywait;
  logic        misaligned;

  modport master (
    output address, write_data, mem_read, mem_write,
    input  read_data, busywait, misaligned
  );

  modport slave (
    input  address, write_data, mem_read, mem_write,
    output read_data, busywait, misaligned
  );
endinterface

// File: rtl/data_mem_responder.sv
// Byte-addressed little-endian data memory with fixed multi-cycle latency;
// holds the pipeline via busywait and sign/zero-extends loads by funct3.
module data_mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 3
) (
  input logic     clk,
  input logic     rst,
  data_mem_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [AW-1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic            store_q;
  logic [1:0]      size_q;
  logic            uns_q;
  logic [31:0]     read_data_q;
  logic            mis_q;
  logic [7:0]      mem_q [DEPTH];

  logic            req;
  logic            commit;
  logic            mis_d;
  logic [31:0]     load_d;
  logic [7:0]      b0, b1, b2, b3;
  logic            unused_addr_hi;

  assign req            = bus.mem_read[3] | bus.mem_write[2];
  assign unused_addr_hi = ^bus.address[31:AW];
  assign commit         = (state_q == ACCESS) && (cnt_q == '0);

  // Size code 00 byte, 01 half, 1x word; unsupported load funct3 falls into word.
  assign mis_d = ((size_q == 2'b01) && addr_q[0]) ||
                 (size_q[1] && (addr_q[1:0] != 2'b00));

  assign b0 = mem_q[addr_q];
  assign b1 = mem_q[addr_q + AW'(1)];
  assign b2 = mem_q[addr_q + AW'(2)];
  assign b3 = mem_q[addr_q + AW'(3)];

  always_comb begin
    load_d = {b3, b2, b1, b0};
    case (size_q)
      2'b00:   load_d = uns_q ? {24'h0, b0} : {{24{b0[7]}}, b0};
      2'b01:   load_d = uns_q ? {16'h0, b1, b0} : {{16{b1[7]}}, b1, b0};
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      store_q     <= 1'b0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      read_data_q <= '0;
      mis_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            addr_q  <= bus.address[AW-1:0];
            wdata_q <= bus.write_data;
            store_q <= bus.mem_write[2];
            // Store wins over a simultaneous load.
            size_q  <= bus.mem_write[2] ? bus.mem_write[1:0] : bus.mem_read[1:0];
            uns_q   <= ~bus.mem_write[2] & bus.mem_read[2];
            cnt_q   <= CW'(LATENCY - 1);
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            mis_q <= mis_d;
            if (!store_q) read_data_q <= mis_d ? '0 : load_d;
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Array is never reset; an async reset forces IDLE, so no commit can follow it.
  always_ff @(posedge clk) begin
    if (commit && store_q && !mis_d) begin
      mem_q[addr_q] <= wdata_q[7:0];
      if (size_q != 2'b00) mem_q[addr_q + AW'(1)] <= wdata_q[15:8];
      if (size_q[1]) begin
        mem_q[addr_q + AW'(2)] <= wdata_q[23:16];
        mem_q[addr_q + AW'(3)] <= wdata_q[31:24];
      end
    end
  end

  assign bus.busywait   = (state_q == ACCESS) || ((state_q == IDLE) && req);
  assign bus.read_data  = read_data_q;
  assign bus.misaligned = mis_q;
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory responder on the MEM stage. It services load/store requests issued by the pipeline, using the same mem_read/mem_write encodings the pipeline registers carry.
- It drives busywait, which freezes every pipeline register while an access is pending.
- Byte-addressed, little-endian, fixed multi-cycle latency.
- Loads are sign/zero-extended per RV32I funct3.

Parameters:
- DEPTH, 1024: memory size in bytes; power of two.
- LATENCY, 3: cycles spent in ACCESS per request; must be ≥1.

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-high
- address  input  32  byte address; only the low log2(DEPTH) bits are used, so addresses wrap modulo DEPTH
- write_data  input  32  store data; the low byte/half/word is used
- mem_read  input  4  [3] load enable; [2:0] funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- mem_write  input  3  [2] store enable; [1:0]: 00 SB, 01 SH, 10 SW
- read_data  output  32  extended load result
- busywait  output  1  high = request pending, pipeline must hold
- misaligned  output  1  last completed access was misaligned

Behaviour:
- Reset:
  - state=IDLE; busywait=0, read_data=0, misaligned=0, counter=0.
  - Memory array is not cleared.
  - Reset mid-ACCESS aborts the request: no bytes written, read_data stays 0.
- Request present = mem_read[3] | mem_write[2]. If both are set, the store wins; the load is ignored and read_data is not updated.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - busywait = request present (combinational, same cycle).
  - On a clock edge with a request present: latch address, write_data and op; counter=LATENCY-1; go to ACCESS.
- ACCESS:
  - busywait=1.
  - While counter>0, decrement it each edge.
  - On the edge where counter==0, commit and go to DONE:
    - Store: write 1/2/4 bytes, little-endian, starting at the latched address.
    - Load: fetch the bytes and register the extended result into read_data.
- DONE:
  - busywait=0, so the pipeline advances on this edge.
  - Next edge: go to IDLE unconditionally. A request visible in DONE is not accepted until IDLE.
- Timing: busywait is high for exactly LATENCY+1 consecutive cycles per request, then low for one cycle (DONE).
- Back-to-back: a new request appearing in IDLE right after DONE starts immediately; there is no idle bubble beyond DONE.
- Alignment:
  - Half accesses need address[0]==0; word accesses need address[1:0]==00.
  - A misaligned access still runs the full latency. It sets misaligned=1 at commit, writes no bytes, and a load returns read_data=0.
  - An aligned commit clears misaligned.
- Extension:
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
  - An unsupported funct3 (011, 110, 111) behaves as LW.
- Stability: read_data holds its value until the next load commits. Stores do not change read_data.
- Wrap: the access window is computed modulo DEPTH; a word at DEPTH-2 is misaligned, so no wrap write occurs.

Test Plan:
1. SW 0x11223344 @0x10, then LW @0x10 → busywait high 4 cycles per request (LATENCY=3), read_data=0x11223344, misaligned=0.
2. After test 1: LB @0x11 → 0x00000033; LBU @0x13 → 0x00000011; LH @0x12 → 0x00001122; LHU @0x10 → 0x00003344.
3. SB 0x000000_80 @0x20, then LB @0x20 → 0xFFFFFF80; LBU @0x20 → 0x00000080. SH 0x8001 @0x22, then LH @0x22 → 0xFFFF8001.
4. LW @0x12 → busywait still 4 cycles, misaligned=1, read_data=0. SH @0x21 → memory @0x20..0x23 unchanged, misaligned=1. Next aligned LW clears misaligned.
5. SW 0xDEADBEEF @0x30; assert rst during the 2nd ACCESS cycle → busywait=0 immediately, then LW @0x30 reads the previous contents (not 0xDEADBEEF).
6. mem_read=4'b1010 and mem_write=3'b110 together @0x40 with data 0xCAFEF00D → store performed; prior read_data unchanged. Address 0x400+0x40 (wraps with DEPTH=1024) LW → 0xCAFEF00D.
